crossing_timer: RTL and testbench



---
 rtl/crossing_timer.sv | 71 +++++++
 tb/tb_crossing_timer.sv | 97 +++++++++
 2 files changed

// File: rtl/crossing_timer.sv
// crossing_timer: prescaled interval timer emitting a one-cycle proceed pulse; optional hold input under CROSSING_TIMER_HOLD_EN
module crossing_timer #(
  parameter int PRESCALE   = 4,
  parameter int BASE_TICKS = 3,
  parameter int PRE_W      = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tr,
  input  logic [1:0]       multiplier,
`ifdef CROSSING_TIMER_HOLD_EN
  input  logic             hold,
`endif
  output logic             proceed,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);
  typedef enum logic {IDLE, COUNT} state_t;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  state_t state, state_n;
  logic [PRE_W-1:0] pre, pre_n;
  logic [CNT_W-1:0] rem_n, load_t;
  logic proceed_n, frz;
`ifdef CROSSING_TIMER_HOLD_EN
  assign frz = hold;
`else
  assign frz = 1'b0;
`endif
  assign load_t = CNT_W'(BASE_TICKS * (int'(multiplier) + 1));
  assign busy = (state == COUNT);
  // state, prescaler, tick count and expiry pulse registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pre       <= '0;
      remaining <= '0;
      proceed   <= 1'b0;
    end else begin
      state     <= state_n;
      pre       <= pre_n;
      remaining <= rem_n;
      proceed   <= proceed_n;
    end
  end
  // a restart always wins; otherwise count ticks and expire on the last one
  always_comb begin
    state_n   = state;
    pre_n     = pre;
    rem_n     = remaining;
    proceed_n = 1'b0;
    if (tr) begin
      state_n = COUNT;
      pre_n   = PRE_MAX;
      rem_n   = load_t;
    end else if (state == COUNT && !frz) begin
      if (pre != '0) begin
        pre_n = pre - 1'b1;
      end else begin
        pre_n = PRE_MAX;
        if (remaining == CNT_W'(1)) begin
          proceed_n = 1'b1;
          rem_n     = '0;
          state_n   = IDLE;
        end else begin
          rem_n = remaining - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_crossing_timer.sv
// tb_crossing_timer: randomized and directed checks of crossing_timer against a deadline-based reference model
module tb_crossing_timer;
  localparam int P = 4;
  localparam int B = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tr = 1'b0;
  logic [1:0] multiplier = 2'b00;
  logic proceed, busy;
  logic [7:0] remaining;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int start = 0;
  int tt = 0;
  bit active = 0;
  bit pr = 0;

  crossing_timer #(.PRESCALE(P), .BASE_TICKS(B), .PRE_W(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .tr(tr), .multiplier(multiplier),
    .proceed(proceed), .busy(busy), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  task automatic step(input bit r, input bit t, input logic [1:0] m);
    @(negedge clk);
    reset = r;
    tr = t;
    multiplier = m;
    @(posedge clk);
    cyc++;
    pr = 0;
    if (!r) active = 0;
    else if (t) begin
      active = 1;
      start = cyc;
      tt = B * (int'(m) + 1);
    end else if (active && cyc == start + P * tt) begin
      active = 0;
      pr = 1;
    end
    #1;
    chk("proceed", int'(proceed), int'(pr));
    chk("busy", int'(busy), int'(active));
    chk("remaining", int'(remaining), active ? tt - (cyc - start) / P : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'($urandom_range(3)));
  endtask

  initial begin
    step(1'b0, 1'b1, 2'b11);
    step(1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b1, 2'b01);
    idle(30);
    step(1'b1, 1'b1, 2'b00);
    idle(14);
    step(1'b1, 1'b1, 2'b11);
    idle(50);
    step(1'b1, 1'b1, 2'b11);
    idle(9);
    step(1'b1, 1'b1, 2'b00);
    idle(50);
    step(1'b1, 1'b1, 2'b01);
    idle(23);
    step(1'b1, 1'b1, 2'b01);
    idle(30);
    step(1'b1, 1'b1, 2'b10);
    idle(36);
    step(1'b1, 1'b1, 2'b00);
    idle(14);
    step(1'b1, 1'b1, 2'b01);
    idle(30);
    step(1'b1, 1'b1, 2'b00);
    idle(18);
    step(1'b1, 1'b1, 2'b11);
    idle(5);
    step(1'b0, 1'b0, 2'b00);
    idle(20);
    step(1'b1, 1'b1, 2'b01);
    idle(30);
    for (int i = 0; i < 4000; i++) begin
      if (pr && $urandom_range(1) == 1) step(1'b1, 1'b1, 2'($urandom_range(3)));
      else step($urandom_range(299) != 0, $urandom_range(39) == 0, 2'($urandom_range(3)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
